// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, tracks up to two in-flight or buffered
// instructions, and presents them to decode with stall, redirect and kill handling.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNT_W = 2;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic [CNT_W-1:0]      kill_q, kill_d;
  logic [CNT_W-1:0]      buf_cnt_q, buf_cnt_d;
  logic [1:0][XLEN-1:0]  aq_q, aq_d;
  entry_t [1:0]          buf_q, buf_d;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       instr_q, instr_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       npc_q, npc_d;

  logic [CNT_W:0]        slots_used;
  logic                  req_c, grant, resp_live, resp_drop, resp_good, load;
  logic                  aq_idx;
  entry_t                resp_entry;

  // Request and response qualification from registered occupancy only
  always_comb begin
    slots_used = {1'b0, outst_q} + {1'b0, buf_cnt_q};
    req_c      = rst_ni && (slots_used < 3'd2);
    grant      = req_c && imem_gnt_i;
    resp_live  = imem_rvalid_i && (outst_q != 2'd0);
    resp_drop  = resp_live && (kill_q != 2'd0);
    resp_good  = resp_live && (kill_q == 2'd0) && !redirect_i;
    load       = !valid_q || !stall_i;
    resp_entry.instr = imem_rdata_i;
    resp_entry.pc    = aq_q[0];
  end

  // Fetch PC, outstanding tracking, granted-address queue and kill counter
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + {1'b0, grant} - {1'b0, resp_live};
    kill_d     = kill_q;
    aq_d       = aq_q;
    aq_idx     = outst_q[0];
    if (resp_live) begin
      aq_d[0] = aq_q[1];
      aq_idx  = 1'b0;
    end
    if (grant) begin
      aq_d[aq_idx] = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + 32'd4;
    end
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ALIGN_MASK;
      kill_d     = outst_d;
    end else if (resp_drop) begin
      kill_d = kill_q - 2'd1;
    end
  end

  // Buffer and output register: buffer head first, then same-cycle bypass
  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    if (redirect_i) begin
      buf_cnt_d = 2'd0;
      valid_d   = 1'b0;
      instr_d   = NOP;
    end else if (load) begin
      if (buf_cnt_q != 2'd0) begin
        valid_d  = 1'b1;
        instr_d  = buf_q[0].instr;
        pc_d     = buf_q[0].pc;
        npc_d    = buf_q[0].pc + 32'd4;
        buf_d[0] = buf_q[1];
        if (resp_good) begin
          buf_d[1'(buf_cnt_q - 2'd1)] = resp_entry;
        end else begin
          buf_cnt_d = buf_cnt_q - 2'd1;
        end
      end else if (resp_good) begin
        valid_d = 1'b1;
        instr_d = resp_entry.instr;
        pc_d    = resp_entry.pc;
        npc_d   = resp_entry.pc + 32'd4;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP;
      end
    end else if (resp_good) begin
      buf_d[buf_cnt_q[0]] = resp_entry;
      buf_cnt_d           = buf_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= BOOT_ADDR & ALIGN_MASK;
      outst_q    <= '0;
      kill_q     <= '0;
      buf_cnt_q  <= '0;
      aq_q       <= '0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      pc_q       <= '0;
      npc_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      buf_cnt_q  <= buf_cnt_d;
      aq_q       <= aq_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
    end
  end

  assign imem_req_o  = req_c;
  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign npc_o       = npc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model plus an architectural model of the expected
// fetch address and the expected program-order instruction stream seen by decode.
module tb_if_stage;

  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, stall;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic        valid;
  logic [31:0] instr, pc, npc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_q[$];
  logic [31:0] exp_fetch = BOOT;
  logic [31:0] exp_pc = BOOT;
  int          consumed = 0;
  bit          seen_wrap = 1'b0;
  bit          hold = 1'b0;
  logic        h_valid;
  logic [31:0] h_instr, h_pc, h_npc;
  logic        l_req, l_valid;
  logic [31:0] l_addr, l_pc;
  int gnt_pct, rv_pct, stall_pct, redir_pct;

  if_stage #(.BOOT_ADDR(BOOT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .valid_o(valid), .instr_o(instr), .pc_o(pc), .npc_o(npc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic set_rv(input bit want);
    imem_rvalid = want && (mem_q.size() > 0);
    imem_rdata  = imem_rvalid ? instr_of(mem_q[0]) : $urandom;
  endtask

  task automatic set_rand();
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    set_rv($urandom_range(99) < rv_pct);
    stall       = ($urandom_range(99) < stall_pct);
    redirect    = ($urandom_range(99) < redir_pct);
    redirect_pc = $urandom;
  endtask

  // One clock: check at negedge, advance the models at posedge
  task automatic step();
    @(negedge clk);
    l_req = imem_req; l_addr = imem_addr; l_valid = valid; l_pc = pc;
    if (!rst_n) begin
      checks++;
      if ({imem_req, valid, instr, pc, npc} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset_values: req=%b valid=%b instr=%h pc=%h npc=%h", imem_req, valid, instr, pc, npc);
      end
    end else begin
      if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_fetch);
        end
      end
      if (mem_q.size() >= 2) begin
        checks++;
        if (imem_req !== 1'b0 || mem_q.size() > 2) begin
          errors++;
          $display("FAIL slot_limit: req=%b outstanding=%0d", imem_req, mem_q.size());
        end
      end
      if (valid !== 1'b1) begin
        checks++;
        if (instr !== NOP || valid !== 1'b0) begin
          errors++;
          $display("FAIL nop_when_invalid: valid=%b instr=%h want 0/%h", valid, instr, NOP);
        end
      end
      if (hold) begin
        checks++;
        if ({valid, instr, pc, npc} !== {h_valid, h_instr, h_pc, h_npc}) begin
          errors++;
          $display("FAIL stall_freeze: got %b %h %h %h want %b %h %h %h", valid, instr, pc, npc, h_valid, h_instr, h_pc, h_npc);
        end
      end
      if (valid === 1'b1 && !stall && !redirect) begin
        checks++;
        if (pc !== exp_pc || instr !== instr_of(exp_pc) || npc !== exp_pc + 32'd4) begin
          errors++;
          $display("FAIL consume: got pc=%h instr=%h npc=%h want pc=%h instr=%h npc=%h", pc, instr, npc, exp_pc, instr_of(exp_pc), exp_pc + 32'd4);
        end
        if (exp_pc == 32'hFFFF_FFFC && npc === 32'h0) seen_wrap = 1'b1;
        consumed++;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      mem_q.delete();
      exp_fetch = BOOT;
      exp_pc    = BOOT;
      hold      = 1'b0;
    end else begin
      if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (l_req && imem_gnt) mem_q.push_back(exp_fetch);
      if (redirect) exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      else if (l_req && imem_gnt) exp_fetch = exp_fetch + 32'd4;
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (l_valid && !stall) exp_pc = exp_pc + 32'd4;
      hold    = l_valid && stall && !redirect;
      h_valid = valid; h_instr = instr; h_pc = pc; h_npc = npc;
    end
    #1;
  endtask

  task automatic quiet_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
  endtask

  task automatic check_release();
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== BOOT) begin
      errors++;
      $display("FAIL release_fetch: req=%b addr=%h want 1/%h", imem_req, imem_addr, BOOT);
    end
  endtask

  task automatic wait_valid_pc(input string name, input logic [31:0] want);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      imem_gnt = 1'b1; set_rv(1'b1); stall = 1'b0; redirect = 1'b0;
      step();
      if (l_valid === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || l_pc !== want) begin
      errors++;
      $display("FAIL %s: found=%b pc=%h want %h", name, found, l_pc, want);
    end
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check_release();
  endtask

  task automatic test_boot_stream();
    logic [31:0] want;
    for (int c = 1; c <= 6; c++) begin
      imem_gnt = 1'b1; stall = 1'b0; redirect = 1'b0;
      set_rv(1'b1);
      if (c == 1) begin imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      step();
      checks++;
      want = BOOT + 32'(4 * (c - 3));
      if ((c < 3 && l_valid !== 1'b0) || (c >= 3 && (l_valid !== 1'b1 || l_pc !== want))) begin
        errors++;
        $display("FAIL boot_stream c%0d: valid=%b pc=%h want %b/%h", c, l_valid, l_pc, c >= 3, want);
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      imem_gnt = 1'b1; set_rv(1'b1); stall = 1'b1; redirect = 1'b0;
      step();
    end
    checks++;
    if (l_req !== 1'b0 || l_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_slots: req=%b valid=%b want 0/1", l_req, l_valid);
    end
    for (int c = 0; c < 10; c++) begin
      imem_gnt = 1'b1; set_rv(1'b1); stall = 1'b0; redirect = 1'b0;
      step();
    end
  endtask

  task automatic test_redirect();
    for (int c = 0; c < 10 && mem_q.size() < 2; c++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b0; stall = 1'b0; redirect = 1'b0;
      step();
    end
    checks++;
    if (mem_q.size() != 2) begin
      errors++;
      $display("FAIL redirect_setup: outstanding=%0d want 2", mem_q.size());
    end
    imem_gnt = 1'b1; imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2002;
    step();
    wait_valid_pc("redirect_target", 32'h0000_2000);
  endtask

  task automatic test_redirect_collide();
    repeat (4) begin imem_gnt = 1'b1; set_rv(1'b1); stall = 1'b0; redirect = 1'b0; step(); end
    imem_gnt = 1'b1; set_rv(1'b1); redirect = 1'b1; redirect_pc = 32'h0000_4001;
    step();
    wait_valid_pc("collide_target", 32'h0000_4000);
  endtask

  task automatic test_wrap();
    seen_wrap = 1'b0;
    imem_gnt = 1'b1; set_rv(1'b1); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF6;
    step();
    repeat (15) begin imem_gnt = 1'b1; set_rv(1'b1); redirect = 1'b0; step(); end
    checks++;
    if (!seen_wrap) begin
      errors++;
      $display("FAIL pc_wrap: pc FFFFFFFC with npc 0 seen=%b want 1", seen_wrap);
    end
  endtask

  task automatic test_gnt_hold_reset();
    logic [31:0] a0;
    imem_gnt = 1'b0; set_rv(1'b0); stall = 1'b0; redirect = 1'b0;
    step();
    a0 = l_addr;
    for (int c = 0; c < 4; c++) begin
      imem_gnt = 1'b0; set_rv(1'b1);
      step();
      checks++;
      if (l_addr !== a0) begin
        errors++;
        $display("FAIL gnt_hold_addr c%0d: got %h want %h", c, l_addr, a0);
      end
    end
    rst_n = 1'b0;
    quiet_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    check_release();
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    wait_valid_pc("post_reset_first", BOOT);
  endtask

  task automatic test_random(input int cycles, input int gp, input int rp, input int sp, input int dp);
    int start = consumed;
    gnt_pct = gp; rv_pct = rp; stall_pct = sp; redir_pct = dp;
    for (int c = 0; c < cycles; c++) begin
      set_rand();
      step();
    end
    checks++;
    if (consumed - start < cycles / 20) begin
      errors++;
      $display("FAIL random_progress: consumed %0d want >= %0d", consumed - start, cycles / 20);
    end
  endtask

  initial begin
    quiet_inputs();
    test_reset();
    test_boot_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_gnt_hold_reset();
    test_random(3000, 70, 60, 30, 3);
    test_random(2000, 95, 95, 10, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 imem_req_o  output  1  fetch request valid.
REQ-005 imem_addr_o  output  32  fetch address, word aligned.
REQ-006 imem_gnt_i  input  1  request accepted when imem_req_o && imem_gnt_i.
REQ-007 imem_rvalid_i  input  1  response valid; responses return in grant order, at least 1 cycle after grant.
REQ-008 imem_rdata_i  input  32  instruction word of the response.
REQ-009 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc_i  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-011 stall_i  input  1  decode stage cannot accept a new instruction.
REQ-012 valid_o  output  1  instr_o/pc_o/npc_o hold a live instruction.
REQ-013 instr_o  output  32  instruction to decode; 32'h0000_0013 (NOP) whenever valid_o=0.
REQ-014 pc_o  output  32  address of instr_o.
REQ-015 npc_o  output  32  pc_o + 4, modulo 2^32.

Function
REQ-016 Fetch PC register: advances by 4 on each grant; wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-017 Slot accounting: outstanding (granted, no response) + buffered entries SHALL never exceed 2; imem_req_o=1 only when that sum < 2, from registered counts only.
REQ-018 While imem_req_o=1 and no grant, imem_addr_o SHALL hold stable; only a redirect may change it.
REQ-019 2-entry in-order buffer stores {instr, pc} per response; pc is captured from an in-order queue of granted addresses.
REQ-020 Output register loads when valid_o=0 or stall_i=0: from buffer head if non-empty, else directly from a live response in the same cycle (bypass), else valid_o<=0.
REQ-021 Latency: grant in cycle t, rvalid in t+1, buffer empty, no stall -> valid_o=1 with that instruction in cycle t+2.
REQ-022 valid_o=1 and stall_i=1 -> instr_o, pc_o, npc_o, valid_o held unchanged; a live response goes to the buffer.
REQ-023 Pop and push in the same cycle SHALL both occur; occupancy unchanged.
REQ-024 Redirect (priority over stall and all else): fetch PC <= redirect_pc_i with [1:0]=0; buffer flushed; valid_o<=0, instr_o<=NOP next cycle.
REQ-025 Redirect: kill counter <= outstanding count after this cycle's grant/response, so a grant in the redirect cycle counts as killed.
REQ-026 While kill counter > 0, each rvalid is dropped and decrements it; dropped responses never reach buffer or outputs.
REQ-027 New requests at the redirect target SHALL issue while kill counter > 0, within the slot limit of REQ-017; killed outstanding count as occupied.
REQ-028 First request after redirect: imem_req_o=1, imem_addr_o=target in the cycle after redirect_i, if a slot is free.
REQ-029 rvalid with no outstanding request is a protocol error and SHALL be ignored.

Reset
REQ-030 While rst_ni=0: imem_req_o=0, valid_o=0, instr_o=32'h0000_0013, pc_o=0, npc_o=0, fetch PC=BOOT_ADDR, buffer empty, outstanding=0, kill counter=0.
REQ-031 Reset mid-transaction discards all outstanding requests; responses arriving after release with outstanding=0 are ignored per REQ-029.
REQ-032 First cycle after release: imem_req_o=1, imem_addr_o=BOOT_ADDR.

Verification
REQ-033 Release reset, BOOT_ADDR=0x100, gnt always 1, rvalid 1 cycle after grant, stall_i=0 -> valid_o from cycle 3, pc_o 0x100, 0x104, 0x108 each cycle, npc_o=pc_o+4.
REQ-034 Stall_i=1 for 5 cycles with valid_o=1 -> outputs frozen, imem_req_o drops when 2 slots used; on release, no instruction lost or duplicated.
REQ-035 Redirect_i to 0x2002 with 2 outstanding requests -> both responses dropped, next imem_addr_o=0x2000, first valid_o shows pc_o=0x2000.
REQ-036 Redirect in the same cycle as a grant and an rvalid -> rvalid instruction dropped, granted request killed, no stale pc_o ever valid.
REQ-037 PC 0xFFFF_FFFC fetched -> npc_o=0x0000_0000, next imem_addr_o=0x0000_0000.
REQ-038 gnt_i held 0 for 4 cycles -> imem_addr_o stable; rst_ni pulsed low mid-stall -> all REQ-030 values, then imem_addr_o=BOOT_ADDR.
